machine_timer: RTL
==================

# machine_timer

Memory-mapped RISC-V machine timer (mtime/mtimecmp) that produces the `time_compare` level consumed by the interrupt controller to raise the machine timer interrupt (mcause 0x8000_0007, mip[7]). It sits on the processor's data-memory bus alongside RAM. Software reads the 64-bit free-running counter and programs the 64-bit compare value through 32-bit word accesses.

## Interface
- `BASE_ADDR`, 32'h0200_4000: base of the 32-byte register window; decode is `addr[31:5] == BASE_ADDR[31:5]`.
- `PRESCALE`, 1: clk cycles per mtime increment; legal range 1..65535.
- `clk` in 1: single clock, rising-edge.
- `resetn` in 1: asynchronous, active-low reset.
- `load` in 1: read request, sampled each cycle.
- `W` in 1: write request, sampled each cycle.
- `addr` in 32: byte address of the access.
- `wdata` in 32: write data.
- `rdata` out 32: registered read data.
- `ack` out 1: one-cycle pulse completing an access.
- `time_compare` out 1: level, high while mtime >= mtimecmp.

## Operation
- Register map (offset from BASE_ADDR):
  - 0x00 MTIME_LO
  - 0x04 MTIME_HI
  - 0x08 MTIMECMP_LO
  - 0x0C MTIMECMP_HI
  - 0x10 CTRL, bit0 = EN; other bits read 0 and ignore writes.
  - 0x14–0x1C reserved: read 0, writes ignored.
- Reset values:
  - mtime = 0.
  - mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF, so no interrupt fires out of reset.
  - EN = 1, prescale counter = 0.
  - rdata = 0, ack = 0, time_compare = 0, hi shadow = 0.
- Tick generation: a 16-bit prescale counter runs while EN = 1. The tick asserts in the cycle the counter equals PRESCALE-1, then the counter returns to 0. With PRESCALE = 1, a tick occurs every cycle.
- mtime increments by 1 on each tick. It is 64-bit unsigned and wraps from 2^64-1 to 0.
- EN = 0 freezes both mtime and the prescale counter. Setting EN = 1 resumes counting from the frozen prescale value.
- Access rules:
  - An access is accepted in any cycle where `load | W` is high and the address decodes to the window.
  - Out-of-window requests get no ack and cause no state change.
  - Every accepted access produces `ack` exactly one cycle later.
  - A request held high for N cycles is N accesses.
  - Misaligned in-window access (`addr[1:0] != 0`): acked, rdata = 0, no register change.
  - `W` and `load` high together: treated as a write; rdata holds its previous value.
- Writes:
  - A word write replaces that 32-bit half at the clock edge.
  - A software write to MTIME_LO/HI takes priority over a tick in the same cycle; the tick is lost.
  - Writing a half does not clear the prescale counter.
- Reads: rdata is loaded from the register value sampled at the request edge, before that edge's update.
- Compare: `time_compare` is registered from the unsigned 64-bit comparison `mtime >= mtimecmp` of the current register contents. It lags the register state by one cycle and stays high until mtimecmp is raised or mtime wraps.
- Software updating mtimecmp writes MTIMECMP_HI = all-ones first, then LO, then HI. The block does not protect against intermediate glitches.

## Timing
- Read: request at edge n, then `rdata` valid and `ack` = 1 during cycle n+1. Back-to-back requests give back-to-back acks.
- Write: the register reflects wdata from edge n. A read of that register at edge n+1 returns the new value.
- time_compare: register state established at edge n is reflected in time_compare at edge n+1.
- Reset asserted mid-access: ack and rdata clear immediately (asynchronously); the pending ack is dropped.

## Configuration
- `MTIMER_SHADOW_EN`:
  - Defined: a read of MTIME_LO also latches mtime[63:32] into a hi shadow register, and MTIME_HI reads return the shadow. An LO-then-HI read pair is therefore coherent across a carry.
  - Undefined: no shadow register exists, and MTIME_HI reads return live mtime[63:32].
  - Writes are identical in both builds.

## Test plan
- Reset, then read all five registers: MTIME = 0 (or small), MTIMECMP halves = 32'hFFFF_FFFF, CTRL = 1, time_compare = 0.
- PRESCALE = 4, EN = 1, 40 idle cycles, then read MTIME_LO: value 10 (±1 for access latency). With EN = 0, two reads 20 cycles apart return equal values.
- Write MTIMECMP_HI = 0 then MTIMECMP_LO = 50 with PRESCALE = 1: time_compare rises exactly one cycle after mtime reaches 50. Writing MTIMECMP_LO = 32'hFFFF_FFFF drops it one cycle later.
- Write MTIME_LO = 32'hFFFF_FFFE, MTIME_HI = 7, then read LO then HI with MTIMER_SHADOW_EN defined: HI returns 7 if LO < 2 was not reached at the LO read, else 8, never 8 paired with LO = 32'hFFFF_FFFF. Without the macro, the same sequence shows the incoherent pair.
- Load mtime = 64'hFFFF_FFFF_FFFF_FFFF: after one tick it reads 0. With mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF, time_compare goes 1 then 0.
- Edge cases:
  - `W` and `load` together at 0x08 with wdata = 5: MTIMECMP_LO = 5, one ack, rdata unchanged.
  - Misaligned address 0x02: ack with rdata 0.
  - Address outside the window: no ack.
  - resetn pulse during a pending read: ack never appears.

Source files
------------

// File: rtl/machine_timer.sv
// rtl/machine_timer.sv - memory-mapped RISC-V machine timer (mtime/mtimecmp)
//
// Ports:
//   clk          : single rising-edge clock
//   resetn       : asynchronous active-low reset
//   load         : read request, sampled every cycle
//   W            : write request, sampled every cycle (wins over load)
//   addr         : byte address of the access
//   wdata        : write data
//   rdata        : registered read data
//   ack          : one-cycle pulse, one cycle after each accepted access
//   time_compare : registered level, high while mtime >= mtimecmp
//
// Parameters:
//   BASE_ADDR    : base of the 32-byte register window
//   PRESCALE     : clk cycles per mtime increment (1..65535)
//
// Build option:
//   MTIMER_SHADOW_EN : when defined, a MTIME_LO read latches mtime[63:32]
//                      into a shadow that MTIME_HI reads return.

module machine_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0200_4000,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        load,
    input  logic        W,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        time_compare
);

    localparam logic [15:0] LP_PRE_MAX = 16'(PRESCALE - 1);

    localparam logic [2:0] LP_MTIME_LO    = 3'd0;
    localparam logic [2:0] LP_MTIME_HI    = 3'd1;
    localparam logic [2:0] LP_MTIMECMP_LO = 3'd2;
    localparam logic [2:0] LP_MTIMECMP_HI = 3'd3;
    localparam logic [2:0] LP_CTRL        = 3'd4;

    logic [63:0] r_mtime;
    logic [63:0] r_mtimecmp;
    logic        r_en;
    logic [15:0] r_pre;

    logic        w_hit;
    logic        w_aligned;
    logic        w_wr;
    logic        w_rd;
    logic [2:0]  w_off;
    logic        w_tick;
    logic [31:0] w_mtime_hi_rd;
    logic [31:0] w_rd_val;

    assign w_hit     = (load | W) && (addr[31:5] == BASE_ADDR[31:5]);
    assign w_aligned = (addr[1:0] == 2'b00);
    assign w_off     = addr[4:2];
    // A combined load+W request behaves as a write.
    assign w_wr      = w_hit & W & w_aligned;
    assign w_rd      = w_hit & load & ~W & w_aligned;
    assign w_tick    = r_en && (r_pre == LP_PRE_MAX);

    // Prescaler freezes (does not clear) while disabled, so re-enabling
    // resumes the partial period.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pre <= 16'd0;
        end else if (r_en) begin
            r_pre <= w_tick ? 16'd0 : r_pre + 16'd1;
        end
    end

    // A software write to either mtime half swallows a coincident tick.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_mtime <= 64'd0;
        end else if (w_wr && w_off == LP_MTIME_LO) begin
            r_mtime[31:0] <= wdata;
        end else if (w_wr && w_off == LP_MTIME_HI) begin
            r_mtime[63:32] <= wdata;
        end else if (w_tick) begin
            r_mtime <= r_mtime + 64'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
            r_en       <= 1'b1;
        end else if (w_wr) begin
            if (w_off == LP_MTIMECMP_LO) r_mtimecmp[31:0]  <= wdata;
            if (w_off == LP_MTIMECMP_HI) r_mtimecmp[63:32] <= wdata;
            if (w_off == LP_CTRL)        r_en              <= wdata[0];
        end
    end

`ifdef MTIMER_SHADOW_EN
    logic [31:0] r_hi_shadow;

    // Capturing the upper half together with the LO read makes an
    // LO-then-HI pair coherent across a carry out of the low word.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_hi_shadow <= 32'd0;
        end else if (w_rd && w_off == LP_MTIME_LO) begin
            r_hi_shadow <= r_mtime[63:32];
        end
    end

    assign w_mtime_hi_rd = r_hi_shadow;
`else
    assign w_mtime_hi_rd = r_mtime[63:32];
`endif

    always_comb begin
        w_rd_val = 32'd0;
        case (w_off)
            LP_MTIME_LO:    w_rd_val = r_mtime[31:0];
            LP_MTIME_HI:    w_rd_val = w_mtime_hi_rd;
            LP_MTIMECMP_LO: w_rd_val = r_mtimecmp[31:0];
            LP_MTIMECMP_HI: w_rd_val = r_mtimecmp[63:32];
            LP_CTRL:        w_rd_val = {31'd0, r_en};
            default:        w_rd_val = 32'd0;
        endcase
    end

    // Misaligned accesses return 0; aligned writes leave rdata untouched.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata <= 32'd0;
            ack   <= 1'b0;
        end else begin
            ack <= w_hit;
            if (w_hit && !w_aligned) begin
                rdata <= 32'd0;
            end else if (w_rd) begin
                rdata <= w_rd_val;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            time_compare <= 1'b0;
        end else begin
            time_compare <= (r_mtime >= r_mtimecmp);
        end
    end

endmodule
